// File: rtl/priority_pkg.sv
// Shared types and helpers for the priority_encoder / edge_mask_decoder pair.
package priority_pkg;

  localparam int WORD_W = 5;
  localparam int IDX_W  = $clog2(WORD_W);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // True when the word has zero or one bit set.
  function automatic logic is_onehot_or_zero(input word_t w);
    return ((w & (w - word_t'(1))) == word_t'(0));
  endfunction

endpackage

// File: rtl/edge_mask_decoder_onehot_to_bin.sv
// Combinational one-hot to binary converter with a multi-hot flag.
// For a multi-hot input the index is the OR of all set positions and
// is meaningless; the caller must qualify it with multi_hot.
module onehot_to_bin #(
  parameter  int WIDTH = 5,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             multi_hot
);

  // OR together the positions of every set bit to form the index.
  always_comb begin
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  always_comb begin
    multi_hot = |(onehot & (onehot - {{(WIDTH-1){1'b0}}, 1'b1}));
  end

endmodule

// File: rtl/edge_mask_decoder.sv
// Expands a leftmost/rightmost one-hot edge pair into the inclusive bit
// mask between the edges. Two-stage valid/ready pipeline: S1 holds the
// edge indices and classification, S2 holds the mask and drives outputs.
module edge_mask_decoder
  import priority_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             data_val_i,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic [IDX_W-1:0] left_idx_o,
  output logic [IDX_W-1:0] right_idx_o,
  output logic             err_o,
  output logic             data_val_o,
  input  logic             ready_i
);

  logic [IDX_W-1:0] left_idx_s;
  logic [IDX_W-1:0] right_idx_s;
  logic             left_multi_s;
  logic             right_multi_s;
  logic             left_zero_s;
  logic             right_zero_s;
  logic             pair_err_s;
  logic             pair_empty_s;
  logic             s2_ready_s;

  logic             s1_val_r;
  logic             s1_err_r;
  logic             s1_empty_r;
  logic [IDX_W-1:0] s1_left_idx_r;
  logic [IDX_W-1:0] s1_right_idx_r;

  logic [WIDTH-1:0] ones_s;
  logic [IDX_W-1:0] shamt_s;
  logic [WIDTH-1:0] mask_s;

  onehot_to_bin #(.WIDTH(WIDTH)) u_left_conv (
    .onehot    (data_left_i),
    .idx       (left_idx_s),
    .multi_hot (left_multi_s)
  );

  onehot_to_bin #(.WIDTH(WIDTH)) u_right_conv (
    .onehot    (data_right_i),
    .idx       (right_idx_s),
    .multi_hot (right_multi_s)
  );

  // Classify the incoming pair: empty, well-formed, or malformed.
  always_comb begin
    left_zero_s  = (data_left_i == {WIDTH{1'b0}});
    right_zero_s = (data_right_i == {WIDTH{1'b0}});
    pair_empty_s = left_zero_s & right_zero_s;
    pair_err_s   = left_multi_s | right_multi_s
                 | (left_zero_s ^ right_zero_s)
                 | (~left_zero_s & ~right_zero_s & (right_idx_s > left_idx_s));
  end

  // Stall control: a stage advances when the stage after it can take data.
  always_comb begin
    s2_ready_s = ~data_val_o | ready_i;
    ready_o    = ~s1_val_r | s2_ready_s;
  end

  // S1 register: indices are zeroed for error pairs so S2 can pass them through.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      s1_val_r       <= 1'b0;
      s1_err_r       <= 1'b0;
      s1_empty_r     <= 1'b0;
      s1_left_idx_r  <= {IDX_W{1'b0}};
      s1_right_idx_r <= {IDX_W{1'b0}};
    end else if (ready_o) begin
      s1_val_r <= data_val_i;
      if (data_val_i) begin
        s1_err_r       <= pair_err_s;
        s1_empty_r     <= pair_empty_s;
        s1_left_idx_r  <= pair_err_s ? {IDX_W{1'b0}} : left_idx_s;
        s1_right_idx_r <= pair_err_s ? {IDX_W{1'b0}} : right_idx_s;
      end
    end
  end

  // Build the inclusive mask from the registered edge indices.
  always_comb begin
    ones_s  = {WIDTH{1'b1}};
    shamt_s = IDX_W'(WIDTH - 1) - s1_left_idx_r;
    if (s1_err_r | s1_empty_r) begin
      mask_s = {WIDTH{1'b0}};
    end else begin
      mask_s = (ones_s << s1_right_idx_r) & (ones_s >> shamt_s);
    end
  end

  // S2 register: drives every output and holds them while stalled.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_val_o  <= 1'b0;
      data_o      <= {WIDTH{1'b0}};
      left_idx_o  <= {IDX_W{1'b0}};
      right_idx_o <= {IDX_W{1'b0}};
      err_o       <= 1'b0;
    end else if (s2_ready_s) begin
      data_val_o <= s1_val_r;
      if (s1_val_r) begin
        data_o      <= mask_s;
        left_idx_o  <= s1_left_idx_r;
        right_idx_o <= s1_right_idx_r;
        err_o       <= s1_err_r;
      end
    end
  end

endmodule

// File: tb/tb_edge_mask_decoder.sv
// Self-checking bench for edge_mask_decoder (WIDTH=5) with a scoreboard queue.
module tb_edge_mask_decoder;

  logic       clk;
  logic       srst_i;
  logic       data_val_i;
  logic [4:0] data_left_i;
  logic [4:0] data_right_i;
  logic       ready_o;
  logic [4:0] data_o;
  logic [2:0] left_idx_o;
  logic [2:0] right_idx_o;
  logic       err_o;
  logic       data_val_o;
  logic       ready_i;

  typedef struct packed {
    logic [4:0] data;
    logic [2:0] li;
    logic [2:0] ri;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  edge_mask_decoder dut (
    .clk_i        (clk),
    .srst_i       (srst_i),
    .data_val_i   (data_val_i),
    .data_left_i  (data_left_i),
    .data_right_i (data_right_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .left_idx_o   (left_idx_o),
    .right_idx_o  (right_idx_o),
    .err_o        (err_o),
    .data_val_o   (data_val_o),
    .ready_i      (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count bits, locate edges, fill the mask bit by bit.
  function automatic exp_t model(input logic [4:0] l, input logic [4:0] r);
    exp_t e;
    int lc, rc, li, ri;
    e = '0; lc = 0; rc = 0; li = 0; ri = 0;
    for (int i = 0; i < 5; i++) begin
      if (l[i]) begin lc++; li = i; end
      if (r[i]) begin rc++; ri = i; end
    end
    if (lc == 0 && rc == 0) begin
      e = '0;
    end else if (lc == 1 && rc == 1 && ri <= li) begin
      for (int i = 0; i < 5; i++)
        if (i >= ri && i <= li) e.data[i] = 1'b1;
      e.li = 3'(li);
      e.ri = 3'(ri);
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  // Output monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (data_val_o === 1'b1 && ready_i === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output data_o=%b err_o=%b (no word expected)", data_o, err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({data_o, left_idx_o, right_idx_o, err_o} !== {e.data, e.li, e.ri, e.err}) begin
          errors++;
          $display("FAIL scoreboard got data=%b l=%0d r=%0d err=%b expected data=%b l=%0d r=%0d err=%b",
                   data_o, left_idx_o, right_idx_o, err_o, e.data, e.li, e.ri, e.err);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word and wait (bounded) until it is accepted.
  task automatic send(input logic [4:0] l, input logic [4:0] r);
    bit acc;
    acc = 1'b0;
    data_left_i  = l;
    data_right_i = r;
    data_val_i   = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      #1;
      acc = ready_o;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      exp_q.push_back(model(l, r));
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready_o=%b expected 1", ready_o);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({data_val_o, data_o, left_idx_o, right_idx_o, err_o} !== 12'd0) begin
      errors++;
      $display("FAIL %s got val=%b data=%b l=%0d r=%0d err=%b expected all 0",
               name, data_val_o, data_o, left_idx_o, right_idx_o, err_o);
    end
  endtask

  task automatic test_reset();
    srst_i = 1'b1; ready_i = 1'b1; data_val_i = 1'b0;
    data_left_i = 5'b00000; data_right_i = 5'b00000;
    cycles(2);
    check_outputs_zero("reset_outputs");
    srst_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b expected 1", ready_o);
    end
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    send(5'b00100, 5'b00001);
    data_val_i = 1'b0;
    checks++;
    if (data_val_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got data_val_o=%b expected 0", data_val_o);
    end
    cycles(1);
    checks++;
    if (data_val_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_2 got data_val_o=%b expected 1", data_val_o);
    end
    cycles(3);
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    send(5'b10000, 5'b00001);
    send(5'b01000, 5'b01000);
    data_val_i = 1'b0;
    checks++;
    if (data_val_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got data_val_o=%b expected 1", data_val_o);
    end
    cycles(1);
    checks++;
    if (data_val_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got data_val_o=%b expected 1", data_val_o);
    end
    cycles(3);
  endtask

  task automatic test_errors();
    ready_i = 1'b1;
    send(5'b00110, 5'b00001);
    send(5'b00001, 5'b00100);
    send(5'b00000, 5'b00010);
    send(5'b00000, 5'b00000);
    send(5'b01000, 5'b00000);
    data_val_i = 1'b0;
    cycles(4);
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    send(5'b00010, 5'b00010);
    send(5'b01000, 5'b00010);
    data_left_i = 5'b10000; data_right_i = 5'b10000; data_val_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_drop got %b expected 0", ready_o);
    end
    for (int c = 0; c < 3; c++) begin
      cycles(1);
      checks++;
      if (data_val_o !== 1'b1 || data_o !== exp_q[0].data || left_idx_o !== exp_q[0].li ||
          ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got val=%b data=%b l=%0d ready_o=%b expected val=1 data=%b l=%0d ready_o=0",
                 data_val_o, data_o, left_idx_o, ready_o, exp_q[0].data, exp_q[0].li);
      end
    end
    ready_i = 1'b1;
    send(5'b10000, 5'b10000);
    data_val_i = 1'b0;
    cycles(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d words pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    ready_i = 1'b0;
    send(5'b00100, 5'b00001);
    send(5'b00001, 5'b00100);
    data_val_i = 1'b0;
    srst_i = 1'b1;
    cycles(1);
    check_outputs_zero("midreset_outputs");
    exp_q.delete();
    srst_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready got %b expected 1", ready_o);
    end
    ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycles(1);
      checks++;
      if (data_val_o !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale got data_val_o=%b expected 0", data_val_o);
      end
    end
  endtask

  task automatic test_ignore_invalid();
    ready_i = 1'b1;
    data_val_i = 1'b0;
    data_left_i = 5'b11111; data_right_i = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      cycles(1);
      checks++;
      if (data_val_o !== 1'b0 || err_o !== 1'b0) begin
        errors++;
        $display("FAIL ignore_invalid got val=%b err=%b expected 0/0", data_val_o, err_o);
      end
    end
  endtask

  initial begin
    srst_i = 1'b1; data_val_i = 1'b0; ready_i = 1'b0;
    data_left_i = 5'b00000; data_right_i = 5'b00000;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_midstream();
    test_ignore_invalid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain got %0d words pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
